// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM for the RV32 core.
// Sequences each instruction and emits datapath selects/enables.
module multicycle_main_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic [1:0]       ALUop,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCSource,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    TRAP   = 4'd9
  } state_t;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_t     state;
  state_t     nxt;
  logic [6:0] op_q;
  logic       ill_q;
  logic       bad;
  logic       mr, mw, irw, pcw, pcc, rw, ret;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      op_q    <= '0;
      instret <= '0;
      ill_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == DECODE) op_q <= opcode;
      if (ret) instret <= instret + CNT_W'(1);
      if (bad) ill_q <= 1'b1;
    end
  end

  always_comb begin
    nxt      = FETCH;
    bad      = 1'b0;
    ALUop    = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    IorD     = 1'b0;
    PCSource = 1'b0;
    MemtoReg = 1'b0;
    mr       = 1'b0;
    mw       = 1'b0;
    irw      = 1'b0;
    pcw      = 1'b0;
    pcc      = 1'b0;
    rw       = 1'b0;
    ret      = 1'b0;
    unique case (state)
      FETCH: begin
        mr      = 1'b1;
        ALUSrcB = 2'b01;
        irw     = mem_ready;
        pcw     = mem_ready;
        nxt     = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LD, OP_ST: nxt = MEMADR;
          OP_R:         nxt = EXEC;
          OP_BR:        nxt = BRANCH;
          default: begin
            nxt = TRAP;
            bad = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (op_q == OP_LD) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mr   = 1'b1;
        IorD = 1'b1;
        nxt  = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        rw       = 1'b1;
        MemtoReg = 1'b1;
        ret      = 1'b1;
      end
      MEMWR: begin
        mw   = 1'b1;
        IorD = 1'b1;
        ret  = mem_ready;
        nxt  = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        nxt     = RWB;
      end
      RWB: begin
        rw  = 1'b1;
        ret = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUop    = 2'b01;
        pcc      = 1'b1;
        PCSource = 1'b1;
        ret      = 1'b1;
      end
      TRAP:    nxt = TRAP;
      default: nxt = FETCH;
    endcase
    // reset in flight kills every side-effecting strobe
    if (rst) begin
      mr  = 1'b0;
      mw  = 1'b0;
      irw = 1'b0;
      pcw = 1'b0;
      pcc = 1'b0;
      rw  = 1'b0;
      ret = 1'b0;
      bad = 1'b0;
    end
  end

  assign MemRead     = mr;
  assign MemWrite    = mw;
  assign IRWrite     = irw;
  assign PCWrite     = pcw;
  assign PCWriteCond = pcc;
  assign RegWrite    = rw;
  assign retire      = ret;
  assign illegal     = ill_q;

endmodule
